// File: rtl/reg_pipe.sv
// Elastic DEPTH-stage valid/ready pipeline register with bubble collapse.
// Optional occupancy counter enabled by defining REG_PIPE_COUNT_EN.
module reg_pipe #(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
`ifdef REG_PIPE_COUNT_EN
    input  logic             out_ready,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
`else
    input  logic             out_ready
`endif
);

    logic [DEPTH-1:0] vld_q;
    logic [WIDTH-1:0] dat_q [DEPTH];
    logic [DEPTH-1:0] rdy;
    logic [DEPTH-1:0] src_vld;
    logic [WIDTH-1:0] src_dat [DEPTH];
    logic             chain;

    // Ready chain: a stage may load if it or any stage downstream is empty,
    // or the consumer is taking the output word.
    always_comb begin
        chain = out_ready;
        rdy   = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            chain  = chain | ~vld_q[k];
            rdy[k] = chain;
        end
    end

    // Source of each stage: producer for stage 0, previous stage otherwise.
    always_comb begin
        src_vld[0] = in_valid;
        src_dat[0] = in_data;
        for (int k = 1; k < DEPTH; k++) begin
            src_vld[k] = vld_q[k-1];
            src_dat[k] = dat_q[k-1];
        end
    end

    // Stage registers: advance when ready, hold on stall, clear on flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                dat_q[k] <= RESET_VAL;
            end
        end else if (flush) begin
            vld_q <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (rdy[k]) begin
                    vld_q[k] <= src_vld[k];
                    if (src_vld[k]) begin
                        dat_q[k] <= src_dat[k];
                    end
                end
            end
        end
    end

    assign in_ready  = rdy[0] & ~flush;
    assign out_valid = vld_q[DEPTH-1] & ~flush;
    assign out_data  = dat_q[DEPTH-1];

`ifdef REG_PIPE_COUNT_EN
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic          in_fire;
    logic          out_fire;
    logic [CW-1:0] cnt_q;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // Word counter tracking the number of valid stages.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            cnt_q <= '0;
        end else if (in_fire && !out_fire) begin
            cnt_q <= cnt_q + CW'(1);
        end else if (out_fire && !in_fire) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign occupancy = cnt_q;
`endif

endmodule

// File: tb/tb_reg_pipe.sv
// Scoreboard bench for reg_pipe: directed fill/stall/flush/reset vectors
// followed by a random valid/ready stretch checked against a queue model.
module tb_reg_pipe;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;
    localparam logic [7:0]  RV    = 8'hA5;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
`ifdef REG_PIPE_COUNT_EN
    logic [$clog2(DEPTH+1)-1:0] occupancy;
`endif

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] exp_q [$];

    reg_pipe #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .RESET_VAL(RV)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
`ifdef REG_PIPE_COUNT_EN
        .out_ready(out_ready),
        .occupancy(occupancy)
`else
        .out_ready(out_ready)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, req, $time);
        end
    endtask

    // Stimulus side of the scoreboard: record every accepted word.
    always @(negedge clk) begin
        if (reset || flush) begin
            exp_q.delete();
        end else if (in_valid && in_ready) begin
            exp_q.push_back(in_data);
        end
    end

    // Monitor: every consumed output word must match the oldest expected.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
                chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
            end
        end
    end

    // One cycle: drive after the edge, check counter, return at negedge.
    task automatic drive(input bit v, input logic [7:0] d, input bit ordy,
                         input bit fl = 1'b0, input bit rs = 1'b0);
        @(posedge clk);
        #1;
`ifdef REG_PIPE_COUNT_EN
        chk("occupancy", 32'(occupancy), 32'(exp_q.size()));
`endif
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        reset     = rs;
        @(negedge clk);
    endtask

    task automatic drain();
        for (int n = 0; n < 64; n++) begin
            drive(1'b0, 8'h00, 1'b1);
            if (exp_q.size() == 0 && !out_valid) break;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        chk("drain_idle", 32'(out_valid), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset held for two cycles.
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 8'h00, 1'b1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'hA5);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Streaming at full rate; output appears DEPTH cycles later.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 8'(i + 1), 1'b1);
            chk("stream_in_ready", 32'(in_ready), 32'd1);
            chk("stream_latency", 32'(out_valid), 32'(i >= DEPTH));
        end
        drain();

        // Single word crawls to the output while downstream stalls.
        drive(1'b1, 8'h11, 1'b0);
        chk("bub_in_ready", 32'(in_ready), 32'd1);
        for (int i = 1; i < DEPTH; i++) begin
            drive(1'b0, 8'h00, 1'b0);
            chk("bub_no_out", 32'(out_valid), 32'd0);
            chk("bub_ready", 32'(in_ready), 32'd1);
        end
        for (int k = 1; k < DEPTH; k++) begin
            drive(1'b1, 8'(8'h11 * (k + 1)), 1'b0);
            chk("fill_in_ready", 32'(in_ready), 32'd1);
            if (k == 1) begin
                chk("bub_arrived", 32'(out_valid), 32'd1);
                chk("bub_data", 32'(out_data), 32'h11);
            end
        end
        drive(1'b1, 8'h99, 1'b0);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        drive(1'b1, 8'h99, 1'b0);
        chk("full_hold", 32'(in_ready), 32'd0);
        chk("full_head", 32'(out_data), 32'h11);
        drive(1'b1, 8'h99, 1'b1);
        chk("full_passthru", 32'(in_ready), 32'd1);
        drain();

        // Flush with three words held.
        drive(1'b1, 8'h31, 1'b0);
        drive(1'b1, 8'h32, 1'b0);
        drive(1'b1, 8'h33, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        drive(1'b1, 8'h34, 1'b1, 1'b1);
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        drive(1'b0, 8'h00, 1'b1);
        chk("post_flush_valid", 32'(out_valid), 32'd0);
        chk("post_flush_data", 32'(out_data), 32'h31);
        chk("post_flush_ready", 32'(in_ready), 32'd1);
        drain();

        // Reset with three words held.
        drive(1'b1, 8'h41, 1'b0);
        drive(1'b1, 8'h42, 1'b0);
        drive(1'b1, 8'h43, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        drive(1'b1, 8'h44, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 8'h00, 1'b1);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_data", 32'(out_data), 32'hA5);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        drain();

        // Random valid/ready traffic against the queue model.
        for (int i = 0; i < 2000; i++) begin
            drive(1'($urandom_range(0, 1)), 8'($urandom),
                  1'($urandom_range(0, 1)));
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
